// File: rtl/frame_output_if.sv
// SRAM mux port and downstream byte-sink handshake for frame_output.
// frame_output drives the master modport; the SRAM mux and byte sink sit on the slave side.
interface frame_output_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  logic              sram_start;
  logic              sram_rw;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output sram_start, sram_rw, sram_addr, out_data, out_valid,
    input  sram_rdata, sram_ready, out_ready
  );

  modport slave (
    input  sram_start, sram_rw, sram_addr, out_data, out_valid,
    output sram_rdata, sram_ready, out_ready
  );
endinterface

// File: rtl/frame_output.sv
// Reads a captured frame from SRAM (START_ADDR..stop_addr) and streams it high byte first.
// Optional FRAME_OUTPUT_EOI_STOP_EN: also end the readout after an accepted FF D9 byte pair.
module frame_output #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_end,
  input  logic [15:0]   stop_addr,
  frame_output_if.master bus,
  output logic          busy,
  output logic          frame_done,
  output logic          error
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    SEND_HI = 3'd4,
    SEND_LO = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fe_q, fe_q2;
  logic                start_q, start_d;
  logic [BYTE_W-1:0]   odata_q, odata_d;
  logic                ovalid_q, ovalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                fe_rise;
  logic                wait_tmo;
  logic                eoi_hit;

  assign fe_rise  = fe_q && !fe_q2;
  assign wait_tmo = (cnt_q == TMO_MAX);

`ifdef FRAME_OUTPUT_EOI_STOP_EN
  logic prev_ff_q, prev_ff_d;
  // The byte on the bus is D9 and the previously accepted byte was FF.
  assign eoi_hit = prev_ff_q && (odata_q == 8'hD9);
`else
  assign eoi_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs. Edge-detect flops reset high so a
  // frame_end level already present at reset release is not a start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= START_ADDR;
      last_q   <= START_ADDR;
      lo_q     <= '0;
      cnt_q    <= '0;
      fe_q     <= 1'b1;
      fe_q2    <= 1'b1;
      start_q  <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      last_q   <= last_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      fe_q     <= frame_end;
      fe_q2    <= fe_q;
      start_q  <= start_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef FRAME_OUTPUT_EOI_STOP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_ff_q <= 1'b0;
    end else begin
      prev_ff_q <= prev_ff_d;
    end
  end
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef FRAME_OUTPUT_EOI_STOP_EN
    prev_ff_d = prev_ff_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (fe_rise) begin
          last_d  = stop_addr;
          addr_d  = START_ADDR;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
`ifdef FRAME_OUTPUT_EOI_STOP_EN
          prev_ff_d = 1'b0;
`endif
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.sram_ready) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (wait_tmo) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      WAIT_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!bus.sram_ready) begin
          cnt_d   = '0;
          state_d = WAIT_HI;
        end else if (wait_tmo) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      // High byte goes straight to the output register; only the low byte is kept.
      WAIT_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.sram_ready) begin
          lo_d     = bus.sram_rdata[7:0];
          odata_d  = bus.sram_rdata[15:8];
          ovalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = SEND_HI;
        end else if (wait_tmo) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      SEND_HI: begin
        ovalid_d = 1'b1;
        if (bus.out_ready) begin
`ifdef FRAME_OUTPUT_EOI_STOP_EN
          prev_ff_d = (odata_q == 8'hFF);
`endif
          if (eoi_hit) begin
            ovalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            odata_d = lo_q;
            state_d = SEND_LO;
          end
        end
      end

      SEND_LO: begin
        ovalid_d = 1'b1;
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
`ifdef FRAME_OUTPUT_EOI_STOP_EN
          prev_ff_d = (odata_q == 8'hFF);
`endif
          if (eoi_hit || (addr_q == last_q)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.sram_start = start_q;
  assign bus.sram_rw    = 1'b0;
  assign bus.sram_addr  = addr_q;
  assign bus.out_data   = odata_q;
  assign bus.out_valid  = ovalid_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign error          = err_q;

endmodule

// File: tb/tb_frame_output.sv
// Directed bench for frame_output: table of readout vectors plus hand sequences for
// start latency, timeout, reset mid-frame and address wrap (second instance at START_ADDR=FFFE).
module tb_frame_output;
  typedef struct {
    logic [15:0] stop;
    bit          bp;
    bit          mem;
    int          nbytes;
    logic [63:0] bytes;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_end_a, frame_end_b;
  logic [15:0] stop_a, stop_b;
  logic        busy_a, done_a, err_a;
  logic        busy_b, done_b, err_b;

  frame_output_if bus_a ();
  frame_output_if bus_b ();

  frame_output u_a (
    .clk        (clk),
    .reset      (reset),
    .frame_end  (frame_end_a),
    .stop_addr  (stop_a),
    .bus        (bus_a.master),
    .busy       (busy_a),
    .frame_done (done_a),
    .error      (err_a)
  );

  frame_output #(.START_ADDR(16'hFFFE)) u_b (
    .clk        (clk),
    .reset      (reset),
    .frame_end  (frame_end_b),
    .stop_addr  (stop_b),
    .bus        (bus_b.master),
    .busy       (busy_b),
    .frame_done (done_b),
    .error      (err_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int starts_a = 0, dcnt_a = 0, dcnt_b = 0;
  int ss_viol = 0, hold_viol = 0, rv_viol = 0;
  bit hang = 1'b0, use_mem = 1'b0, bp_mode = 1'b0;
  logic [15:0] mem [4];
  logic [7:0]  got_a [$];
  logic [7:0]  got_b [$];
  logic [15:0] addrs_b [$];
  vec_t        vecs [4];

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return use_mem ? mem[a[1:0]] : {a[7:0], ~a[7:0]};
  endfunction

  // SRAM model A: ready low for 3 cycles after each start, optionally stuck low.
  logic [1:0]  lat_a;
  logic [15:0] raddr_a;
  always @(posedge clk) begin
    if (!reset) begin
      bus_a.sram_ready <= 1'b1;
      bus_a.sram_rdata <= 16'h0000;
      lat_a <= 2'd0;
    end else if (bus_a.sram_start && bus_a.sram_ready) begin
      bus_a.sram_ready <= 1'b0;
      lat_a   <= 2'd3;
      raddr_a <= bus_a.sram_addr;
    end else if (!bus_a.sram_ready && !hang) begin
      if (lat_a == 2'd1) begin
        bus_a.sram_ready <= 1'b1;
        bus_a.sram_rdata <= word_of(raddr_a);
      end
      lat_a <= lat_a - 2'd1;
    end
  end

  // SRAM model B: same timing, also records every requested address.
  logic [1:0]  lat_b;
  logic [15:0] raddr_b;
  always @(posedge clk) begin
    if (!reset) begin
      bus_b.sram_ready <= 1'b1;
      bus_b.sram_rdata <= 16'h0000;
      lat_b <= 2'd0;
    end else if (bus_b.sram_start && bus_b.sram_ready) begin
      bus_b.sram_ready <= 1'b0;
      lat_b   <= 2'd3;
      raddr_b <= bus_b.sram_addr;
      addrs_b.push_back(bus_b.sram_addr);
    end else if (!bus_b.sram_ready) begin
      if (lat_b == 2'd1) begin
        bus_b.sram_ready <= 1'b1;
        bus_b.sram_rdata <= {raddr_b[7:0], ~raddr_b[7:0]};
      end
      lat_b <= lat_b - 2'd1;
    end
  end

  // Sink A: ready held high or toggled every cycle.
  initial begin
    bus_a.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_a.out_ready = bp_mode ? ~bus_a.out_ready : 1'b1;
    end
  end

  initial bus_b.out_ready = 1'b1;

  // Protocol monitor, sampled mid-cycle.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  bit         prev_rdy   = 1'b1;
  bit         rv_pend    = 1'b0;
  always @(negedge clk) begin
    if (bus_a.out_valid && bus_a.out_ready) got_a.push_back(bus_a.out_data);
    if (bus_b.out_valid && bus_b.out_ready) got_b.push_back(bus_b.out_data);
    if (done_a) dcnt_a++;
    if (done_b) dcnt_b++;
    if (bus_a.sram_start) starts_a++;
    if (bus_a.sram_start && !bus_a.sram_ready) ss_viol++;
    if (bus_b.sram_start && !bus_b.sram_ready) ss_viol++;
    if (prev_stall && (!bus_a.out_valid || bus_a.out_data != prev_data)) hold_viol++;
    if (rv_pend && !bus_a.out_valid) rv_viol++;
    prev_stall = bus_a.out_valid && !bus_a.out_ready;
    prev_data  = bus_a.out_data;
    rv_pend    = bus_a.sram_ready && !prev_rdy && busy_a;
    prev_rdy   = bus_a.sram_ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_a();
    @(posedge clk);
    #1 frame_end_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 frame_end_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, s0, h0, r0, n;
    logic [15:0] exp_addr [4];
    logic [63:0] exp_b;
    bit          seen;

    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF;
    exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    mem[0] = 16'h01FF; mem[1] = 16'hD955; mem[2] = 16'h1234; mem[3] = 16'h0000;

    vecs[0] = '{16'd3, 1'b0, 1'b0, 8, 64'h00FF_01FE_02FD_03FC};
    vecs[1] = '{16'd1, 1'b1, 1'b0, 4, 64'h00FF_01FE_0000_0000};
    vecs[2] = '{16'd0, 1'b0, 1'b0, 2, 64'h00FF_0000_0000_0000};
`ifdef FRAME_OUTPUT_EOI_STOP_EN
    vecs[3] = '{16'd2, 1'b0, 1'b1, 3, 64'h01FF_D900_0000_0000};
`else
    vecs[3] = '{16'd2, 1'b0, 1'b1, 6, 64'h01FF_D955_1234_0000};
`endif

    // Reset with frame_end already high: released without a start.
    reset = 1'b0; frame_end_a = 1'b1; frame_end_b = 1'b0; stop_a = 16'd0; stop_b = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_sram_start", 32'(bus_a.sram_start), 32'd0);
    check("rst_sram_rw",    32'(bus_a.sram_rw),    32'd0);
    check("rst_sram_addr",  32'(bus_a.sram_addr),  32'h0000);
    check("rst_out_data",   32'(bus_a.out_data),   32'h00);
    check("rst_out_valid",  32'(bus_a.out_valid),  32'd0);
    check("rst_busy",       32'(busy_a),           32'd0);
    check("rst_frame_done", 32'(done_a),           32'd0);
    check("rst_error",      32'(err_a),            32'd0);
    check("rst_b_addr",     32'(bus_b.sram_addr),  32'hFFFE);
    repeat (8) @(posedge clk);
    #1;
    check("level_no_start_busy",   32'(busy_a),   32'd0);
    check("level_no_start_starts", 32'(starts_a), 32'd0);
    frame_end_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Start latency: frame_end rises, sram_start high after the third edge.
    stop_a = 16'd0;
    got_a.delete();
    frame_end_a = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_a.sram_start) break;
    end
    check("start_latency", 32'(n), 32'd3);
    frame_end_a = 1'b0;
    wait_done_a("latency");

    // Table of readout vectors.
    for (int v = 0; v < 4; v++) begin
      got_a.delete();
      d0 = dcnt_a; h0 = hold_viol; r0 = rv_viol;
      stop_a  = vecs[v].stop;
      use_mem = vecs[v].mem;
      bp_mode = vecs[v].bp;
      pulse_a();
      wait_done_a($sformatf("vec%0d", v));
      bp_mode = 1'b0;
      use_mem = 1'b0;
      check($sformatf("vec%0d_nbytes", v), 32'(got_a.size()), 32'(vecs[v].nbytes));
      for (int k = 0; k < vecs[v].nbytes && k < got_a.size(); k++)
        check($sformatf("vec%0d_byte%0d", v, k), 32'(got_a[k]), 32'(vecs[v].bytes[63-8*k -: 8]));
      check($sformatf("vec%0d_done_pulses", v), 32'(dcnt_a - d0), 32'd1);
      check($sformatf("vec%0d_error", v), 32'(err_a), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy_a), 32'd0);
      check($sformatf("vec%0d_hold", v), 32'(hold_viol - h0), 32'd0);
      check($sformatf("vec%0d_valid_lat", v), 32'(rv_viol - r0), 32'd0);
    end

    // Timeout: SRAM never returns ready after the first start.
    hang = 1'b1; stop_a = 16'd3; d0 = dcnt_a; s0 = starts_a;
    pulse_a();
    wait_done_a("tmo");
    check("tmo_error", 32'(err_a), 32'd1);
    check("tmo_done_pulses", 32'(dcnt_a - d0), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("tmo_single_start", 32'(starts_a - s0), 32'd1);
    check("tmo_error_sticky", 32'(err_a), 32'd1);
    check("tmo_idle", 32'(busy_a), 32'd0);
    hang = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Next start clears the sticky error.
    got_a.delete(); stop_a = 16'd0;
    pulse_a();
    check("err_cleared_on_start", 32'(err_a), 32'd0);
    wait_done_a("errclr");
    check("errclr_nbytes", 32'(got_a.size()), 32'd2);

    // Reset mid-frame after three bytes, then restart from START_ADDR.
    got_a.delete(); stop_a = 16'd3; d0 = dcnt_a;
    pulse_a();
    for (int i = 0; i < 300 && got_a.size() < 3; i++) @(negedge clk);
    check("rstmid_reached", 32'(got_a.size() >= 3), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_sram_start", 32'(bus_a.sram_start), 32'd0);
    check("rstmid_sram_addr",  32'(bus_a.sram_addr),  32'h0000);
    check("rstmid_out_data",   32'(bus_a.out_data),   32'h00);
    check("rstmid_out_valid",  32'(bus_a.out_valid),  32'd0);
    check("rstmid_busy",       32'(busy_a),           32'd0);
    check("rstmid_done",       32'(done_a),           32'd0);
    check("rstmid_error",      32'(err_a),            32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_done_pulse", 32'(dcnt_a - d0), 32'd0);
    got_a.delete(); stop_a = 16'd1;
    pulse_a();
    wait_done_a("restart");
    check("restart_nbytes", 32'(got_a.size()), 32'd4);
    if (got_a.size() == 4) begin
      check("restart_b0", 32'(got_a[0]), 32'h00);
      check("restart_b1", 32'(got_a[1]), 32'hFF);
      check("restart_b2", 32'(got_a[2]), 32'h01);
      check("restart_b3", 32'(got_a[3]), 32'hFE);
    end

    // Address wrap on instance B: FFFE..0001.
    got_b.delete(); addrs_b.delete(); stop_b = 16'd1; d0 = dcnt_b;
    @(posedge clk);
    #1 frame_end_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 frame_end_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    check("wrap_done_seen", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_nreq", 32'(addrs_b.size()), 32'd4);
    for (int k = 0; k < 4 && k < addrs_b.size(); k++)
      check($sformatf("wrap_addr%0d", k), 32'(addrs_b[k]), 32'(exp_addr[k]));
    exp_b = 64'hFE01_FF00_00FF_01FE;
    check("wrap_nbytes", 32'(got_b.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_b.size(); k++)
      check($sformatf("wrap_byte%0d", k), 32'(got_b[k]), 32'(exp_b[63-8*k -: 8]));
    check("wrap_done_pulses", 32'(dcnt_b - d0), 32'd1);
    check("wrap_error", 32'(err_b), 32'd0);

    check("start_while_not_ready", 32'(ss_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
